// File: rtl/uart_mmio_fifo_pkg.sv
// uart_pkg: register offsets, STATUS/CTRL bit indices and the shared FSM state type
package uart_pkg;
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_RXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;
    localparam int ST_RX_OVR    = 5;
    localparam int ST_FRAME_ERR = 6;
    localparam int ST_TX_OVR    = 7;
    localparam int CT_LOOPBACK  = 16;
    localparam int CT_RX_IRQ_EN = 17;
    localparam int CT_TX_IRQ_EN = 18;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// sync_fifo: circular-buffer FIFO with registered storage and a combinational head
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [LW-1:0] level_q;
    logic do_pop, do_push;
    // a push into a full FIFO is accepted only when a pop frees the head slot in the same cycle
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign full_o  = level_q == LW'(DEPTH);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign data_o  = mem_q[rd_q];
    // storage write, no reset needed since level gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    // pointer and level bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped 8N1 UART with TX/RX FIFOs, runtime divisor, loopback and irq
module uart_mmio_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int DIV_RESET   = 868,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        UART_Rx,
    output logic        UART_Tx,
    output logic        irq
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic [1:0] off;
    logic tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head;
    logic [LW-1:0] rx_level, unused_tx_level;
    logic [DIV_W-1:0] div_q, tx_div_q, rx_div_q, tx_cnt_q, rx_cnt_q;
    logic loopback_q, rx_irq_en_q, tx_irq_en_q, rx_ovr_q, frame_err_q, tx_ovr_q, irq_q;
    logic rx_ovr_d, frame_err_d, tx_ovr_d, irq_d;
    uart_state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [2:0] tx_bit_q, rx_bit_q;
    logic [7:0] tx_shift_q, rx_shift_q;
    logic tx_tick, tx_busy, tx_ser;
    logic [SYNC_STAGES-1:0] sync_q;
    logic rx_in, rx_s, rx_prev_q, rx_fall, rx_tick, rx_half_tick, rx_ferr;
    logic sts_wr, ctrl_wr;
    logic [31:0] status, ctrl;
    logic unused_bits;

    assign unused_bits = ^{address, data_in};
    assign off     = address[3:2];
    assign tx_push = wr_en & (off == OFF_TXDATA);
    assign rx_pop  = rd_en & ~wr_en & (off == OFF_RXDATA) & ~rx_empty;
    assign sts_wr  = wr_en & (off == OFF_STATUS);
    assign ctrl_wr = wr_en & (off == OFF_CTRL);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push_i(tx_push), .pop_i(tx_pop), .data_i(data_in[7:0]),
        .data_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .level_o(unused_tx_level)
    );
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push_i(rx_push), .pop_i(rx_pop), .data_i(rx_shift_q),
        .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level)
    );

    assign status = {16'b0, 8'(rx_level), tx_ovr_q, frame_err_q, rx_ovr_q, tx_busy,
                     rx_empty, rx_full, tx_empty, tx_full};
    assign ctrl   = {13'b0, tx_irq_en_q, rx_irq_en_q, loopback_q, 16'(div_q)};
    assign data_out = !rd_en ? 32'b0 :
                      off == OFF_RXDATA ? (rx_empty ? 32'b0 : {24'b0, rx_head}) :
                      off == OFF_STATUS ? status :
                      off == OFF_CTRL ? ctrl : 32'b0;

    // sticky flags: a set event in the same cycle as a write-1-to-clear wins
    always_comb begin
        tx_ovr_d    = (tx_ovr_q & ~(sts_wr & data_in[ST_TX_OVR])) | (tx_push & tx_full & ~tx_pop);
        rx_ovr_d    = (rx_ovr_q & ~(sts_wr & data_in[ST_RX_OVR])) | (rx_push & rx_full & ~rx_pop);
        frame_err_d = (frame_err_q & ~(sts_wr & data_in[ST_FRAME_ERR])) | rx_ferr;
        irq_d       = (rx_irq_en_q & (~rx_empty | rx_ovr_q | frame_err_q)) | (tx_irq_en_q & tx_empty);
    end

    // control register, sticky flags and registered interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= DIV_W'(DIV_RESET);
            loopback_q  <= 1'b0;
            rx_irq_en_q <= 1'b0;
            tx_irq_en_q <= 1'b0;
            tx_ovr_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            tx_ovr_q    <= tx_ovr_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
            if (ctrl_wr) begin
                div_q       <= data_in[DIV_W-1:0] < DIV_W'(2) ? DIV_W'(2) : data_in[DIV_W-1:0];
                loopback_q  <= data_in[CT_LOOPBACK];
                rx_irq_en_q <= data_in[CT_RX_IRQ_EN];
                tx_irq_en_q <= data_in[CT_TX_IRQ_EN];
            end
        end
    end
    assign irq = irq_q;

    assign tx_tick = tx_cnt_q == tx_div_q - DIV_W'(1);
    // TX state register
    always_ff @(posedge clk) begin
        if (reset) tx_state_q <= IDLE;
        else tx_state_q <= tx_state_d;
    end
    // TX next state: the end of STOP chains straight into START when more data waits
    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            IDLE:  tx_state_d = tx_empty ? IDLE : START;
            START: if (tx_tick) tx_state_d = DATA;
            DATA:  if (tx_tick && tx_bit_q == 3'd7) tx_state_d = STOP;
            STOP:  if (tx_tick) tx_state_d = tx_empty ? IDLE : START;
        endcase
    end
    // TX outputs: FIFO pop at frame start and the serial line level
    always_comb begin
        tx_pop  = ~tx_empty & ((tx_state_q == IDLE) | (tx_state_q == STOP & tx_tick));
        tx_busy = tx_state_q != IDLE;
        tx_ser  = tx_state_q == START ? 1'b0 : tx_state_q == DATA ? tx_shift_q[0] : 1'b1;
    end
    // TX datapath: byte and divisor captured at frame start, bit timing thereafter
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_div_q   <= DIV_W'(DIV_RESET);
        end else if (tx_pop) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= tx_head;
            tx_div_q   <= div_q;
        end else if (tx_busy) begin
            tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + DIV_W'(1);
            if (tx_state_q == DATA && tx_tick) begin
                tx_shift_q <= tx_shift_q >> 1;
                tx_bit_q   <= tx_bit_q + 3'd1;
            end
        end
    end
    assign UART_Tx = loopback_q | tx_ser;

    assign rx_in        = loopback_q ? tx_ser : UART_Rx;
    assign rx_s         = sync_q[SYNC_STAGES-1];
    assign rx_fall      = rx_prev_q & ~rx_s;
    assign rx_tick      = rx_cnt_q == rx_div_q - DIV_W'(1);
    assign rx_half_tick = rx_cnt_q == (rx_div_q >> 1) - DIV_W'(1);
    // input synchroniser and falling-edge history, idle high
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
            rx_prev_q <= rx_s;
        end
    end
    // RX state register
    always_ff @(posedge clk) begin
        if (reset) rx_state_q <= IDLE;
        else rx_state_q <= rx_state_d;
    end
    // RX next state: a start bit that is high again at its centre is treated as a glitch
    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            IDLE:  if (rx_fall) rx_state_d = START;
            START: if (rx_half_tick) rx_state_d = rx_s ? IDLE : DATA;
            DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = STOP;
            STOP:  if (rx_tick) rx_state_d = IDLE;
        endcase
    end
    // RX outputs: stop-bit centre decides between pushing the byte and flagging a frame error
    always_comb begin
        rx_push = (rx_state_q == STOP) & rx_tick & rx_s;
        rx_ferr = (rx_state_q == STOP) & rx_tick & ~rx_s;
    end
    // RX datapath: divisor follows CTRL while idle and freezes for the frame
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_div_q   <= DIV_W'(DIV_RESET);
        end else if (rx_state_q == IDLE) begin
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_div_q <= div_q;
        end else begin
            rx_cnt_q <= (rx_state_q == START ? rx_half_tick : rx_tick) ? '0 : rx_cnt_q + DIV_W'(1);
            if (rx_state_q == DATA && rx_tick) begin
                rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                rx_bit_q   <= rx_bit_q + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// tb_uart_mmio_fifo: scoreboard bench with a serial-line TX monitor and randomized frames
module tb_uart_mmio_fifo;
    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    logic clk = 0, reset = 1, wr_en = 0, rd_en = 0, UART_Rx = 1;
    logic [31:0] address = 0, data_in = 0, data_out;
    logic UART_Tx, irq;
    int tests = 0, fails = 0, frames = 0, mon_div = 4;
    bit mon_en = 0;
    logic [7:0] tx_exp[$], rx_exp[$];

    uart_mmio_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .DIV_RESET(868), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .address(address), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out), .UART_Rx(UART_Rx), .UART_Tx(UART_Tx), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address = {28'b0, a};
        data_in = d;
        wr_en = 1;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        address = {28'b0, a};
        rd_en = 1;
        #1 d = data_out;
        @(negedge clk);
        rd_en = 0;
    endtask

    // drive one 8N1 frame on UART_Rx; optionally read RXDATA on negedge index rd_at
    task automatic send_rx(input logic [7:0] b, input logic stop, input int div, input int rd_at,
                           output logic [31:0] rdv);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        rdv = 0;
        for (int k = 0; k < 10 * div + 4; k++) begin
            @(negedge clk);
            UART_Rx = k < 10 * div ? f[k / div] : 1'b1;
            rd_en = 0;
            if (k == rd_at) begin
                address = 32'h4;
                rd_en = 1;
                #1 rdv = data_out;
            end
        end
        @(negedge clk);
        rd_en = 0;
        UART_Rx = 1;
    endtask

    // serial monitor: decodes frames on UART_Tx at bit centres and pops the expected byte
    always @(negedge UART_Tx) if (mon_en) begin : mon
        logic [9:0] f;
        repeat (mon_div / 2) @(posedge clk);
        #1 f[0] = UART_Tx;
        for (int i = 1; i < 10; i++) begin
            repeat (mon_div) @(posedge clk);
            #1 f[i] = UART_Tx;
        end
        if (mon_en) begin
            frames++;
            check("tx_start_bit", f[0], 0);
            check("tx_stop_bit", f[9], 1);
            if (tx_exp.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_frame: got %0h expected no frame", f[8:1]);
            end else check("tx_frame", f[8:1], tx_exp.pop_front());
        end
    end

    initial begin
        logic [31:0] v;
        logic [43:0] wave, busy, wexp, bexp;
        logic [9:0] fr;
        logic [7:0] b;
        int lows, c;
        repeat (3) @(negedge clk);
        reset = 0;
        check("rst_tx", UART_Tx, 1);
        check("rst_irq", irq, 0);
        rd(8, v); check("rst_status", v, 32'h0A);
        rd(12, v); check("rst_ctrl", v, 868);
        wr(12, 1); rd(12, v); check("div_min", v, 2);

        wr(12, 4);
        mon_div = 4;
        mon_en = 1;
        tx_exp.push_back(8'h55);
        wr(0, 32'h55);
        address = 32'h8;
        rd_en = 1;
        fr = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            wave[k] = UART_Tx;
            busy[k] = data_out[4];
            wexp[k] = k < 40 ? fr[k / 4] : 1'b1;
            bexp[k] = k < 40;
        end
        rd_en = 0;
        check("tx_wave_55", wave, wexp);
        check("tx_busy_40", busy, bexp);

        wr(12, 6);
        mon_div = 6;
        for (int i = 0; i < DEPTH + 2; i++) begin
            b = 8'($urandom);
            if (i < DEPTH + 1) tx_exp.push_back(b);
            wr(0, {24'b0, b});
        end
        rd(8, v);
        check("tx_full", v[0], 1);
        check("tx_ovr", v[7], 1);
        wr(8, 32'h80);
        rd(8, v);
        check("tx_ovr_clr", v[7], 0);
        check("tx_full_kept", v[0], 1);
        for (c = 0; c < 3000 && tx_exp.size() != 0; c++) @(negedge clk);
        check("tx_drain", tx_exp.size(), 0);
        repeat (8) @(negedge clk);
        rd(8, v);
        check("tx_idle_empty", v[1], 1);
        check("tx_idle_busy", v[4], 0);
        check("tx_frame_count", frames, DEPTH + 2);

        wr(12, 32'h10004);
        wr(0, 32'hA3);
        lows = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!UART_Tx) lows++;
        end
        check("lb_tx_held", lows, 0);
        rd(8, v); check("lb_rx_nonempty", v[3], 0);
        rd(4, v); check("lb_rxdata", v, 32'hA3);
        rd(8, v); check("lb_rx_empty", v[3], 1);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            rx_exp.push_back(b);
            wr(0, {24'b0, b});
        end
        v = 0;
        for (c = 0; c < 100 && v[15:8] != 5; c++) rd(8, v);
        check("lb_level", v[15:8], 5);
        for (int i = 0; i < 5; i++) begin
            rd(4, v);
            check("lb_rand", v, {24'b0, rx_exp.pop_front()});
        end

        wr(12, 32'h20004);
        repeat (2) @(negedge clk);
        check("irq_idle", irq, 0);
        send_rx(8'h3C, 1'b0, 4, -1, v);
        repeat (4) @(negedge clk);
        rd(8, v);
        check("ferr_flag", v[6], 1);
        check("ferr_no_push", v[3], 1);
        check("ferr_irq", irq, 1);
        wr(8, 32'h40);
        repeat (3) @(negedge clk);
        rd(8, v);
        check("ferr_clr", v[6], 0);
        check("irq_clr", irq, 0);

        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            rx_exp.push_back(b);
            send_rx(b, 1'b1, 4, -1, v);
        end
        rd(8, v);
        check("rx_full", v[2], 1);
        check("rx_level_full", v[15:8], DEPTH);
        check("rx_irq", irq, 1);
        b = 8'($urandom);
        send_rx(b, 1'b1, 4, SYNC + 1 + 4 / 2 + 9 * 4 - 1, v);
        check("coinc_read", v, {24'b0, rx_exp.pop_front()});
        rx_exp.push_back(b);
        rd(8, v);
        check("coinc_level", v[15:8], DEPTH);
        check("coinc_no_ovr", v[5], 0);
        b = 8'($urandom);
        send_rx(b, 1'b1, 4, -1, v);
        rd(8, v);
        check("rx_ovr", v[5], 1);
        check("rx_ovr_level", v[15:8], DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            rd(4, v);
            check("rx_drain", v, {24'b0, rx_exp.pop_front()});
        end
        rd(4, v); check("rx_empty_read", v, 0);
        wr(8, 32'h20);
        rd(8, v);
        check("rx_ovr_clr", v[5], 0);
        check("rx_empty_end", v[3], 1);

        wr(12, 32'h40004);
        repeat (3) @(negedge clk);
        check("tx_irq", irq, 1);

        mon_en = 0;
        wr(12, 4);
        wr(0, 32'hF0);
        repeat (15) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("rst_mid_tx", UART_Tx, 1);
        reset = 0;
        rd(8, v);
        check("rst_mid_tx_empty", v[1], 1);
        check("rst_mid_tx_busy", v[4], 0);
        rd(12, v);
        check("rst_mid_div", v, 868);
        check("rst_mid_irq", irq, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
